// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI response codes, ID width and arbiter state encoding
package axi_pkg;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam int ID_W = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} wr_state_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin grant; prio breaks the tie when both are valid
module rr_pick2 (
  input  logic [1:0] valid_i,
  input  logic       prio_i,
  output logic       grant_o
);
  assign grant_o = &valid_i ? prio_i : valid_i[1];
endmodule

// File: rtl/axi_write_arbiter.sv
// axi_write_arbiter: round-robin scheduler of two single-burst write clients onto one AXI3 write path
module axi_write_arbiter
  import axi_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic            ACLK,
  input  logic            ARESET,
  input  logic            req0_valid,
  input  logic            req1_valid,
  input  logic [31:0]     req0_addr,
  input  logic [31:0]     req1_addr,
  input  logic [31:0]     req0_data,
  input  logic [31:0]     req1_data,
  input  logic [3:0]      req0_len,
  input  logic [3:0]      req1_len,
  output logic            req0_ready,
  output logic            req1_ready,
  output logic            req0_done,
  output logic            req1_done,
  output logic [1:0]      req0_resp,
  output logic [1:0]      req1_resp,
  output logic            mem_write,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_data,
  output logic [3:0]      mem_len,
  output logic [ID_W-1:0] mem_id,
  input  logic            mem_done,
  input  logic [1:0]      mem_resp,
  output logic            busy
);
  wr_state_t state_q, state_d;
  logic prio_q, prio_d, grant_q, grant_d, pick;
  logic write_q, write_d;
  logic [ID_W-2:0] tag_q, tag_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] bresp_q, bresp_d, ready_q, ready_d, done_q, done_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [3:0] len_q, len_d;
  logic [ID_W-1:0] id_q, id_d;
  rr_pick2 u_pick (
    .valid_i({req1_valid, req0_valid}),
    .prio_i (prio_q),
    .grant_o(pick)
  );
  // Every output is a register loaded on the edge that enters the state showing it.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    bresp_d = bresp_q;
    addr_d  = addr_q;
    data_d  = data_q;
    len_d   = len_q;
    id_d    = id_q;
    ready_d = 2'b00;
    write_d = 1'b0;
    done_d  = 2'b00;
    unique case (state_q)
      IDLE: if (req0_valid || req1_valid) begin
        grant_d = pick;
        addr_d  = pick ? req1_addr : req0_addr;
        data_d  = pick ? req1_data : req0_data;
        len_d   = pick ? req1_len : req0_len;
        id_d    = {tag_q, pick};
        ready_d = pick ? 2'b10 : 2'b01;
        write_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        tag_d   = tag_q + 1'b1;
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: if (mem_done || cnt_q == 8'(TIMEOUT - 1)) begin
        bresp_d = mem_done ? mem_resp : SLVERR;
        done_d  = grant_q ? 2'b10 : 2'b01;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      RESP: begin
        prio_d  = ~grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      grant_q <= 1'b0;
      tag_q   <= '0;
      cnt_q   <= 8'd0;
      bresp_q <= OKAY;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      len_q   <= 4'd0;
      id_q    <= '0;
      ready_q <= 2'b00;
      write_q <= 1'b0;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      bresp_q <= bresp_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      len_q   <= len_d;
      id_q    <= id_d;
      ready_q <= ready_d;
      write_q <= write_d;
      done_q  <= done_d;
    end
  end
  assign req0_ready = ready_q[0];
  assign req1_ready = ready_q[1];
  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_resp  = done_q[0] ? bresp_q : OKAY;
  assign req1_resp  = done_q[1] ? bresp_q : OKAY;
  assign mem_write  = write_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign mem_len    = len_q;
  assign mem_id     = id_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_axi_write_arbiter.sv
// tb_axi_write_arbiter: directed vector table plus hand-written multi-cycle sequences
module tb_axi_write_arbiter;
  import axi_pkg::*;
  logic ACLK = 1'b0, ARESET = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, mem_done = 1'b0;
  logic [31:0] req0_addr = 32'h2, req0_data = 32'h1, req1_addr = 32'h100, req1_data = 32'hAB;
  logic [3:0] req0_len = 4'd3, req1_len = 4'd5, mem_len, mem_id;
  logic [1:0] mem_resp = 2'b00, req0_resp, req1_resp;
  logic req0_ready, req1_ready, req0_done, req1_done, mem_write, busy;
  logic [31:0] mem_addr, mem_data;
  int n_chk = 0, n_fail = 0;
  axi_write_arbiter #(.TIMEOUT(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_len(req0_len), .req1_len(req1_len),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_done(req0_done), .req1_done(req1_done),
    .req0_resp(req0_resp), .req1_resp(req1_resp),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_len(mem_len), .mem_id(mem_id),
    .mem_done(mem_done), .mem_resp(mem_resp), .busy(busy)
  );
  always #5 ACLK = ~ACLK;
  typedef struct {
    logic v0, v1, md;
    logic [1:0] mr, rdy;
    logic wr;
    logic [3:0] id;
    logic [1:0] dn, r0, r1;
    logic bsy;
    logic [31:0] addr;
  } vec_t;
  vec_t tbl[17];
  function automatic vec_t mk(int v0, int v1, int md, int mr, int rdy, int wr, int id,
                              int dn, int r0, int r1, int bsy, logic [31:0] addr);
    vec_t m;
    m.v0 = v0[0]; m.v1 = v1[0]; m.md = md[0]; m.mr = mr[1:0]; m.rdy = rdy[1:0];
    m.wr = wr[0]; m.id = id[3:0]; m.dn = dn[1:0]; m.r0 = r0[1:0]; m.r1 = r1[1:0];
    m.bsy = bsy[0]; m.addr = addr;
    return m;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge ACLK);
    @(negedge ACLK);
  endtask
  task automatic do_reset;
    ARESET = 1'b1;
    step;
    step;
    ARESET = 1'b0;
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " ready"}, 32'({req1_ready, req0_ready}), 32'd0);
    chk({nm, " done"}, 32'({req1_done, req0_done}), 32'd0);
    chk({nm, " resp"}, 32'({req1_resp, req0_resp}), 32'd0);
    chk({nm, " write"}, 32'(mem_write), 32'd0);
    chk({nm, " addr"}, mem_addr, 32'd0);
    chk({nm, " data"}, mem_data, 32'd0);
    chk({nm, " len"}, 32'(mem_len), 32'd0);
    chk({nm, " id"}, 32'(mem_id), 32'd0);
    chk({nm, " busy"}, 32'(busy), 32'd0);
  endtask
  initial begin
    tbl[0]  = mk(1,0,0,0, 1,1,0,0,0,0,1,32'h2);
    tbl[1]  = mk(0,0,0,0, 0,0,0,0,0,0,1,32'h2);
    tbl[2]  = mk(0,0,1,0, 0,0,0,1,0,0,1,32'h2);
    tbl[3]  = mk(0,0,0,0, 0,0,0,0,0,0,0,32'h2);
    tbl[4]  = mk(0,1,0,0, 2,1,3,0,0,0,1,32'h100);
    tbl[5]  = mk(0,0,0,0, 0,0,3,0,0,0,1,32'h100);
    tbl[6]  = mk(0,0,0,0, 0,0,3,0,0,0,1,32'h100);
    tbl[7]  = mk(0,0,1,3, 0,0,3,2,0,3,1,32'h100);
    tbl[8]  = mk(0,0,1,0, 0,0,3,0,0,0,0,32'h100);
    tbl[9]  = mk(1,1,0,0, 1,1,4,0,0,0,1,32'h2);
    tbl[10] = mk(0,1,0,0, 0,0,4,0,0,0,1,32'h2);
    tbl[11] = mk(0,1,1,1, 0,0,4,1,1,0,1,32'h2);
    tbl[12] = mk(0,1,0,0, 0,0,4,0,0,0,0,32'h2);
    tbl[13] = mk(0,1,0,0, 2,1,7,0,0,0,1,32'h100);
    tbl[14] = mk(0,0,0,0, 0,0,7,0,0,0,1,32'h100);
    tbl[15] = mk(0,0,1,0, 0,0,7,2,0,0,1,32'h100);
    tbl[16] = mk(0,0,0,0, 0,0,7,0,0,0,0,32'h100);
    #1 chk_zero("async reset");
    do_reset;
    chk_zero("reset");
    // table: single request, error response, round-robin with ignored valids/late done
    foreach (tbl[i]) begin
      req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
      mem_done = tbl[i].md; mem_resp = tbl[i].mr;
      step;
      chk($sformatf("vec%0d ready", i), 32'({req1_ready, req0_ready}), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d write", i), 32'(mem_write), 32'(tbl[i].wr));
      chk($sformatf("vec%0d id", i), 32'(mem_id), 32'(tbl[i].id));
      chk($sformatf("vec%0d done", i), 32'({req1_done, req0_done}), 32'(tbl[i].dn));
      chk($sformatf("vec%0d resp0", i), 32'(req0_resp), 32'(tbl[i].r0));
      chk($sformatf("vec%0d resp1", i), 32'(req1_resp), 32'(tbl[i].r1));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("vec%0d addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("vec%0d data", i), mem_data, tbl[i].addr == 32'h2 ? 32'h1 : 32'hAB);
      chk($sformatf("vec%0d len", i), 32'(mem_len), tbl[i].addr == 32'h2 ? 32'd3 : 32'd5);
    end
    mem_done = 1'b0; mem_resp = OKAY; req0_valid = 1'b0; req1_valid = 1'b0;
    // contention from reset
    do_reset;
    req0_valid = 1'b1; req1_valid = 1'b1;
    step;
    chk("cont a ready", 32'({req1_ready, req0_ready}), 32'b01);
    chk("cont a id", 32'(mem_id), 32'h0);
    req0_valid = 1'b0;
    step;
    mem_done = 1'b1;
    step;
    mem_done = 1'b0;
    chk("cont a done", 32'({req1_done, req0_done}), 32'b01);
    step;
    chk("cont idle ready", 32'({req1_ready, req0_ready}), 32'b00);
    step;
    chk("cont b ready", 32'({req1_ready, req0_ready}), 32'b10);
    chk("cont b id", 32'(mem_id), 32'h3);
    req1_valid = 1'b0;
    step;
    mem_done = 1'b1;
    step;
    mem_done = 1'b0;
    chk("cont b done", 32'({req1_done, req0_done}), 32'b10);
    step;
    req0_valid = 1'b1; req1_valid = 1'b1;
    step;
    chk("cont c ready", 32'({req1_ready, req0_ready}), 32'b01);
    chk("cont c id", 32'(mem_id), 32'h4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    // timeout: WAIT entered, RESP exactly 8 cycles later, late done ignored
    do_reset;
    req1_valid = 1'b1;
    step;
    chk("to ready", 32'({req1_ready, req0_ready}), 32'b10);
    req1_valid = 1'b0;
    step;
    for (int k = 1; k < 8; k++) begin
      step;
      chk($sformatf("to wait%0d done", k), 32'({req1_done, req0_done}), 32'b00);
      chk($sformatf("to wait%0d busy", k), 32'(busy), 32'd1);
    end
    step;
    chk("to done", 32'({req1_done, req0_done}), 32'b10);
    chk("to resp1", 32'(req1_resp), 32'(SLVERR));
    step;
    chk("to idle busy", 32'(busy), 32'd0);
    mem_done = 1'b1; mem_resp = OKAY;
    step;
    mem_done = 1'b0;
    chk("late done ignored", 32'({req1_done, req0_done}), 32'b00);
    chk("late done busy", 32'(busy), 32'd0);
    step;
    chk("late done after", 32'({req1_done, req0_done, busy}), 32'd0);
    // tag wrap over 9 back-to-back req0 transactions
    do_reset;
    for (int i = 0; i < 9; i++) begin
      req0_valid = 1'b1;
      step;
      chk($sformatf("wrap%0d id", i), 32'(mem_id), 32'((2 * i) % 16));
      chk($sformatf("wrap%0d write", i), 32'(mem_write), 32'd1);
      req0_valid = 1'b0;
      step;
      mem_done = 1'b1;
      step;
      mem_done = 1'b0;
      chk($sformatf("wrap%0d done", i), 32'({req1_done, req0_done}), 32'b01);
      step;
    end
    // reset mid-WAIT
    do_reset;
    req0_valid = 1'b1;
    step;
    req0_valid = 1'b0;
    step;
    chk("midrst busy before", 32'(busy), 32'd1);
    #2 ARESET = 1'b1;
    #1 chk_zero("midrst");
    step;
    step;
    ARESET = 1'b0;
    mem_done = 1'b1; mem_resp = DECERR;
    step;
    mem_done = 1'b0;
    chk("post rst done", 32'({req1_done, req0_done, busy}), 32'd0);
    req1_valid = 1'b1;
    step;
    chk("post rst ready", 32'({req1_ready, req0_ready}), 32'b10);
    chk("post rst id", 32'(mem_id), 32'h1);
    req1_valid = 1'b0;
    step;
    mem_done = 1'b1; mem_resp = DECERR;
    step;
    mem_done = 1'b0;
    chk("post rst done1", 32'({req1_done, req0_done}), 32'b10);
    chk("post rst resp1", 32'(req1_resp), 32'(DECERR));
    step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
